// File: rtl/dest_select_decoder_pkg.sv
// Shared bus code definitions: destination (load) codes, source (drive) codes
// and the destination-select FSM encoding.
package dest_select_decoder_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned LOAD_W = 32;
  localparam int unsigned XFER_W = 8;

  typedef enum logic [CODE_W-1:0] {
    DEST_R0        = 5'd0,
    DEST_R1        = 5'd1,
    DEST_R2        = 5'd2,
    DEST_R3        = 5'd3,
    DEST_R4        = 5'd4,
    DEST_R5        = 5'd5,
    DEST_R6        = 5'd6,
    DEST_R7        = 5'd7,
    DEST_R8        = 5'd8,
    DEST_R9        = 5'd9,
    DEST_R10       = 5'd10,
    DEST_R11       = 5'd11,
    DEST_R12       = 5'd12,
    DEST_R13       = 5'd13,
    DEST_R14       = 5'd14,
    DEST_R15       = 5'd15,
    DEST_HI        = 5'd16,
    DEST_LO        = 5'd17,
    DEST_ZHIGH     = 5'd18,
    DEST_ZLOW      = 5'd19,
    DEST_PC        = 5'd20,
    DEST_MDR       = 5'd21,
    DEST_OUT_PORT  = 5'd22,
    DEST_HILO_PAIR = 5'd24
  } dest_code_e;

  // Codes the bus-source encoder uses to select which register drives the bus.
  typedef enum logic [CODE_W-1:0] {
    SRC_R0         = 5'd0,
    SRC_R1         = 5'd1,
    SRC_R2         = 5'd2,
    SRC_R3         = 5'd3,
    SRC_R4         = 5'd4,
    SRC_R5         = 5'd5,
    SRC_R6         = 5'd6,
    SRC_R7         = 5'd7,
    SRC_R8         = 5'd8,
    SRC_R9         = 5'd9,
    SRC_R10        = 5'd10,
    SRC_R11        = 5'd11,
    SRC_R12        = 5'd12,
    SRC_R13        = 5'd13,
    SRC_R14        = 5'd14,
    SRC_R15        = 5'd15,
    SRC_HI         = 5'd16,
    SRC_LO         = 5'd17,
    SRC_ZHIGH      = 5'd18,
    SRC_ZLOW       = 5'd19,
    SRC_PC         = 5'd20,
    SRC_MDR        = 5'd21,
    SRC_IN_PORT    = 5'd22,
    SRC_C_SIGN_EXT = 5'd23
  } src_code_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PAIR_LO = 1'b1
  } dest_state_e;

  function automatic logic is_valid_dest(input logic [CODE_W-1:0] code);
    is_valid_dest = (code <= DEST_OUT_PORT) || (code == DEST_HILO_PAIR);
  endfunction

  function automatic logic [LOAD_W-1:0] dest_mask(input logic [CODE_W-1:0] code);
    dest_mask = {{(LOAD_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/dest_select_decoder_onehot.sv
// Combinational destination-code check and one-hot decode.
module dest_code_onehot
  import dest_select_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [LOAD_W-1:0] onehot,
  output logic              valid
);

  always_comb begin
    valid  = is_valid_dest(code);
    onehot = '0;
    if (valid) begin
      onehot = dest_mask(code);
    end
  end

endmodule

// File: rtl/dest_select_decoder.sv
// Registered destination-select decoder: turns accepted destination codes into
// one-cycle load strobes, sequencing the HI/LO pair over two cycles.
module dest_select_decoder
  import dest_select_decoder_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_code,
  output logic              req_ready,
  output logic [LOAD_W-1:0] load_en,
  output logic              busy,
  output logic              err_invalid,
  output logic [CODE_W-1:0] err_code,
  input  logic              err_clear,
  output logic [XFER_W-1:0] xfer_count
);

  dest_state_e       state;
  dest_state_e       state_next;
  logic [LOAD_W-1:0] load_next;
  logic [LOAD_W-1:0] code_onehot;
  logic              code_valid;
  logic              accept;
  logic              set_err;

  dest_code_onehot u_onehot (
    .code   (req_code),
    .onehot (code_onehot),
    .valid  (code_valid)
  );

  // Handshake outputs depend on state alone so the control unit sees no
  // combinational loop through req_valid/req_code.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state == PAIR_LO);
  end

  always_comb begin
    state_next = state;
    load_next  = '0;
    set_err    = 1'b0;
    accept     = req_valid && req_ready;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_code == DEST_HILO_PAIR) begin
            load_next  = dest_mask(DEST_HI);
            state_next = PAIR_LO;
          end else if (code_valid) begin
            load_next = code_onehot;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      PAIR_LO: begin
        load_next  = dest_mask(DEST_LO);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      load_en <= '0;
    end else begin
      state   <= state_next;
      load_en <= load_next;
    end
  end

  // A new invalid accept wins over a simultaneous err_clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      err_invalid <= 1'b0;
      err_code    <= '0;
    end else if (set_err) begin
      err_invalid <= 1'b1;
      err_code    <= req_code;
    end else if (err_clear) begin
      err_invalid <= 1'b0;
    end
  end

  // Counts alongside the strobe register so the count includes the strobe
  // currently on load_en.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      xfer_count <= '0;
    end else if ((load_next != '0) && (xfer_count != '1)) begin
      xfer_count <= xfer_count + XFER_W'(1);
    end
  end

endmodule

// File: tb/tb_dest_select_decoder.sv
// Table-driven bench for dest_select_decoder with directed corner sequences.
module tb_dest_select_decoder;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic [4:0]  req_code;
  logic        req_ready;
  logic [31:0] load_en;
  logic        busy;
  logic        err_invalid;
  logic [4:0]  err_code;
  logic        err_clear;
  logic [7:0]  xfer_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  dest_select_decoder dut (
    .clock       (clock),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_code    (req_code),
    .req_ready   (req_ready),
    .load_en     (load_en),
    .busy        (busy),
    .err_invalid (err_invalid),
    .err_code    (err_code),
    .err_clear   (err_clear),
    .xfer_count  (xfer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [4:0]  code;
    logic        eclr;
    logic [31:0] exp_load;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_err;
    logic [4:0]  exp_ecode;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [4:0] c, input logic ec,
                              input logic [31:0] ld, input logic rdy, input logic bsy,
                              input logic er, input logic [4:0] erc, input logic [7:0] cnt);
    vec_t t;
    t.valid = v; t.code = c; t.eclr = ec; t.exp_load = ld; t.exp_ready = rdy;
    t.exp_busy = bsy; t.exp_err = er; t.exp_ecode = erc; t.exp_count = cnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] ld, input logic rdy,
                           input logic bsy, input logic er, input logic [4:0] erc,
                           input logic [7:0] cnt);
    check({tag, ".load_en"}, load_en, ld);
    check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".err_invalid"}, 32'(err_invalid), 32'(er));
    check({tag, ".err_code"}, 32'(err_code), 32'(erc));
    check({tag, ".xfer_count"}, 32'(xfer_count), 32'(cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b0; req_valid = 1'b0; req_code = '0; err_clear = 1'b0;

    vecs.push_back(mk(1, 5'd5,  0, 32'h0000_0020, 1, 0, 0, 5'd0,  8'd1));
    vecs.push_back(mk(0, 5'd5,  0, 32'h0000_0000, 1, 0, 0, 5'd0,  8'd1));
    vecs.push_back(mk(1, 5'd20, 0, 32'h0010_0000, 1, 0, 0, 5'd0,  8'd2));
    vecs.push_back(mk(1, 5'd21, 0, 32'h0020_0000, 1, 0, 0, 5'd0,  8'd3));
    vecs.push_back(mk(1, 5'd0,  0, 32'h0000_0001, 1, 0, 0, 5'd0,  8'd4));
    vecs.push_back(mk(1, 5'd24, 0, 32'h0001_0000, 0, 1, 0, 5'd0,  8'd5));
    vecs.push_back(mk(1, 5'd3,  0, 32'h0002_0000, 1, 0, 0, 5'd0,  8'd6));
    vecs.push_back(mk(1, 5'd3,  0, 32'h0000_0008, 1, 0, 0, 5'd0,  8'd7));
    vecs.push_back(mk(0, 5'd0,  0, 32'h0000_0000, 1, 0, 0, 5'd0,  8'd7));
    vecs.push_back(mk(1, 5'd23, 0, 32'h0000_0000, 1, 0, 1, 5'd23, 8'd7));
    vecs.push_back(mk(1, 5'd31, 1, 32'h0000_0000, 1, 0, 1, 5'd31, 8'd7));
    vecs.push_back(mk(0, 5'd0,  1, 32'h0000_0000, 1, 0, 0, 5'd31, 8'd7));
    vecs.push_back(mk(1, 5'd22, 0, 32'h0040_0000, 1, 0, 0, 5'd31, 8'd8));
    vecs.push_back(mk(1, 5'd15, 0, 32'h0000_8000, 1, 0, 0, 5'd31, 8'd9));
    vecs.push_back(mk(1, 5'd25, 0, 32'h0000_0000, 1, 0, 1, 5'd25, 8'd9));
    vecs.push_back(mk(0, 5'd0,  0, 32'h0000_0000, 1, 0, 1, 5'd25, 8'd9));

    #3;
    check_all("reset", 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    tick();
    check_all("reset_clk", 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("post_reset.req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      req_valid = vecs[i].valid;
      req_code  = vecs[i].code;
      err_clear = vecs[i].eclr;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_load, vecs[i].exp_ready,
                vecs[i].exp_busy, vecs[i].exp_err, vecs[i].exp_ecode, vecs[i].exp_count);
    end
    req_valid = 1'b0; err_clear = 1'b0;

    // Reset asserted asynchronously while in PAIR_LO.
    req_valid = 1'b1; req_code = 5'd24;
    tick();
    req_valid = 1'b0;
    check_all("pair_start", 32'h0001_0000, 1'b0, 1'b1, 1'b1, 5'd25, 8'd10);
    #2 clear = 1'b0;
    #1;
    check_all("async_reset", 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    @(negedge clock);
    clear = 1'b1;
    tick();
    check_all("after_release", 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    tick();
    check_all("after_release2", 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);

    // Saturation over 300 back-to-back accepts.
    req_valid = 1'b1; req_code = 5'd1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 255 || n == 256 || n == 300) begin
        check($sformatf("sat%0d.count", n), 32'(xfer_count), 32'd255);
      end
      if (n == 100) begin
        check("sat100.count", 32'(xfer_count), 32'd100);
      end
    end
    check("sat.load_en", load_en, 32'h0000_0002);
    req_valid = 1'b0;
    tick();
    check_all("sat_idle", 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
